// File: rtl/lynx_via_pkg.sv
// ---------------------------------------------------------------------------
// lynx_via_pkg
//
// Shared definitions for the Lynx dependency-point vias (via_n_m and its
// via_in_slot input sub-module).
//
// A flit carries a small header at its MSB end, followed by a sequence
// number that fills the remaining low bits:
//   [WIDTH-1      -: A] source router node
//   [WIDTH-1-A    -: A] destination router node
//   [WIDTH-1-2A   -: 8] channel id
//   [WIDTH-2A-9 :  0]   sequence number (wraps modulo 2^(WIDTH-2A-8))
//
// The helper functions below return these field positions from WIDTH and
// the router address width A. They are constant functions, so they can be
// used to size localparams.
// ---------------------------------------------------------------------------
package lynx_via_pkg;

    // 8-bit source/sink channel identifier
    typedef logic [7:0] via_id_t;

    // Header view of a flit for routers up to 16 address bits. Real
    // instances slice their own A-bit fields; this struct documents the
    // field order for tools and scripts that decode traces.
    typedef struct packed {
        logic [15:0] src;
        logic [15:0] dst;
        via_id_t     id;
    } flit_hdr_t;

    // MSB of the source-node field
    function automatic int src_msb(input int width, input int a);
        return width - 1;
    endfunction

    // MSB of the destination-node field
    function automatic int dst_msb(input int width, input int a);
        return width - 1 - a;
    endfunction

    // MSB of the 8-bit id field
    function automatic int id_msb(input int width, input int a);
        return width - 1 - 2 * a;
    endfunction

    // MSB of the sequence field (its LSB is always bit 0)
    function automatic int seq_msb(input int width, input int a);
        return width - 2 * a - 9;
    endfunction

    // Number of bits in the sequence field
    function automatic int seq_width(input int width, input int a);
        return width - 2 * a - 8;
    endfunction

endpackage

// File: rtl/via_in_slot.sv
// ---------------------------------------------------------------------------
// via_in_slot
//
// One input channel of the via: token buffer, ready generation, saturating
// receive counter and (optionally) a sequence-number checker.
//
// Optional feature: define VIA_SEQ_CHECK_EN to build the sequence checker.
// Without it, seq_err is tied low and no checker logic is built.
//
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-low reset
//   flit_in    in   WIDTH-bit flit presented on this input
//   valid_in   in   flit valid
//   ready_out  out  slot can take a flit (token count below DEPTH)
//   fire       in   via fires this cycle, one token is consumed
//   has_token  out  at least one token is buffered
//   rx_done    out  receive counter has reached DONE_COUNT
//   seq_err    out  sticky sequence error
// ---------------------------------------------------------------------------
module via_in_slot
    import lynx_via_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int A           = 4,
    parameter int DEPTH       = 4,
    parameter int INIT_TOKENS = 1,
    parameter int DONE_COUNT  = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] flit_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic             fire,
    output logic             has_token,
    output logic             rx_done,
    output logic             seq_err
);

    localparam int TW = $clog2(DEPTH + 1);
    localparam int RW = $clog2(DONE_COUNT + 1) + 1;
    localparam int SW = seq_width(WIDTH, A);

    logic [TW-1:0] tok;
    logic [RW-1:0] rx;
    logic          accept;

    // Ready comes straight from the token count so a full slot refuses the
    // flit in the same cycle and nothing is ever dropped.
    assign ready_out = (tok < TW'(DEPTH));
    assign accept    = valid_in & ready_out;
    assign has_token = (tok != '0);
    assign rx_done   = (rx >= RW'(DONE_COUNT));

    // Token counter: an accept and a fire in the same cycle cancel out.
    // fire is only raised while has_token is set, so this never underflows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tok <= TW'(INIT_TOKENS);
        end else if (accept && !fire) begin
            tok <= tok + 1'b1;
        end else if (!accept && fire) begin
            tok <= tok - 1'b1;
        end
    end

    // Receive counter saturates so done stays asserted once reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx <= '0;
        end else if (accept && (rx < RW'(DONE_COUNT))) begin
            rx <= rx + 1'b1;
        end
    end

`ifdef VIA_SEQ_CHECK_EN
    logic [SW-1:0] exp_seq;
    logic [SW-1:0] rx_seq;
    logic          unused_hdr;

    assign rx_seq     = flit_in[seq_msb(WIDTH, A):0];
    assign unused_hdr = ^flit_in[WIDTH-1:SW];

    // Sequence checker: a mismatch latches the error, and the expected
    // value resyncs to the received seq + 1 so a single gap is reported
    // once rather than on every following flit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_seq <= '0;
            seq_err <= 1'b0;
        end else if (accept) begin
            exp_seq <= rx_seq + 1'b1;
            if (rx_seq != exp_seq) begin
                seq_err <= 1'b1;
            end
        end
    end
`else
    logic unused_flit;

    assign unused_flit = ^flit_in;
    assign seq_err     = 1'b0;
`endif

endmodule

// File: rtl/via_n_m.sv
// ---------------------------------------------------------------------------
// via_n_m
//
// Generalised Lynx dependency point for NoC traffic simulation. NUM_IN sink
// ports each buffer up to DEPTH tokens. When every input holds a token and
// every output is free (or being drained this cycle), the via fires: one
// token is consumed from each input and one flit is launched on each output.
// Output flits carry src=NODE, a destination taken round-robin from that
// output's destination list, the output id and a per-output sequence
// number.
//
// Optional feature: define VIA_SEQ_CHECK_EN to enable per-input sequence
// checking (seq_err). Without it seq_err is constant zero.
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-low reset
//   done         out  sticky: DONE_COUNT fires and DONE_COUNT flits on
//                     every input
//   i_data_in    in   NUM_IN*WIDTH packed input flits
//   i_valid_in   in   per-input valid
//   i_ready_out  out  per-input ready
//   o_data_out   out  NUM_OUT*WIDTH packed output flits
//   o_dest_out   out  NUM_OUT*A per-output destination router
//   o_valid_out  out  per-output valid
//   o_ready_in   in   per-output ready
//   seq_err      out  per-input sticky sequence error
// ---------------------------------------------------------------------------
module via_n_m
    import lynx_via_pkg::*;
#(
    parameter int NUM_IN       = 2,
    parameter int NUM_OUT      = 2,
    parameter int WIDTH        = 32,
    parameter int N            = 16,
    parameter int N_ADDR_WIDTH = $clog2(N),
    parameter int NODE         = 15,
    parameter int DEPTH        = 4,
    parameter int INIT_TOKENS  = 1,
    parameter int MAX_DEST     = 4,
    parameter logic [NUM_OUT*8-1:0] O_ID       = {NUM_OUT{8'd0}},
    parameter logic [NUM_IN*8-1:0]  I_ID       = {NUM_IN{8'd0}},
    parameter logic [NUM_OUT*8-1:0] O_NUM_DEST = {NUM_OUT{8'd1}},
    parameter logic [NUM_OUT*MAX_DEST*N_ADDR_WIDTH-1:0] O_DEST = '0,
    parameter int DONE_COUNT   = 1000
) (
    input  logic                            clk,
    input  logic                            rst,
    output logic                            done,
    input  logic [NUM_IN*WIDTH-1:0]         i_data_in,
    input  logic [NUM_IN-1:0]               i_valid_in,
    output logic [NUM_IN-1:0]               i_ready_out,
    output logic [NUM_OUT*WIDTH-1:0]        o_data_out,
    output logic [NUM_OUT*N_ADDR_WIDTH-1:0] o_dest_out,
    output logic [NUM_OUT-1:0]              o_valid_out,
    input  logic [NUM_OUT-1:0]              o_ready_in,
    output logic [NUM_IN-1:0]               seq_err
);

    localparam int A  = N_ADDR_WIDTH;
    localparam int SW = seq_width(WIDTH, A);
    localparam int DW = (MAX_DEST > 1) ? $clog2(MAX_DEST) : 1;
    localparam int FW = $clog2(DONE_COUNT + 1) + 1;
    localparam logic [A-1:0] NODE_ADDR = A'(NODE);

    logic [NUM_IN-1:0]  has_token;
    logic [NUM_IN-1:0]  rx_done;
    logic [NUM_OUT-1:0] out_free;
    logic [NUM_OUT-1:0] out_hs;
    logic               fire;
    logic [FW-1:0]      fires;

    // An output can take a new flit if it is empty or its current flit is
    // leaving this cycle, which lets fires run back to back at full rate.
    assign out_hs   = o_valid_out & o_ready_in;
    assign out_free = ~o_valid_out | o_ready_in;
    assign fire     = (&has_token) && (&out_free);

    // One token/ready/checker slot per input
    for (genvar i = 0; i < NUM_IN; i++) begin : g_in
        via_in_slot #(
            .WIDTH       (WIDTH),
            .A           (A),
            .DEPTH       (DEPTH),
            .INIT_TOKENS (INIT_TOKENS),
            .DONE_COUNT  (DONE_COUNT)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .flit_in   (i_data_in[i*WIDTH +: WIDTH]),
            .valid_in  (i_valid_in[i]),
            .ready_out (i_ready_out[i]),
            .fire      (fire),
            .has_token (has_token[i]),
            .rx_done   (rx_done[i]),
            .seq_err   (seq_err[i])
        );
    end

    // Per-output flit register, sequence counter and destination rotation
    for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
        localparam logic [7:0] ID_J    = O_ID[j*8 +: 8];
        localparam logic [7:0] NDEST_J = O_NUM_DEST[j*8 +: 8];

        logic [SW-1:0]    sent;
        logic [DW-1:0]    didx;
        logic [A-1:0]     dest_sel;
        logic             last_dest;
        logic [WIDTH-1:0] data_q;
        logic [A-1:0]     dest_q;
        logic             valid_q;

        assign dest_sel  = O_DEST[(j*MAX_DEST + int'(didx))*A +: A];
        assign last_dest = ((int'(didx) + 1) >= int'(NDEST_J));

        // A fire always reloads the register (the output is known free);
        // otherwise a completed handshake empties it. Data and dest only
        // change on fire, so they stay stable while the sink stalls.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                dest_q  <= '0;
                sent    <= '0;
                didx    <= '0;
            end else if (fire) begin
                valid_q <= 1'b1;
                dest_q  <= dest_sel;
                data_q  <= {NODE_ADDR, dest_sel, ID_J, sent};
                sent    <= sent + 1'b1;
                didx    <= last_dest ? '0 : didx + 1'b1;
            end else if (out_hs[j]) begin
                valid_q <= 1'b0;
            end
        end

        assign o_valid_out[j]          = valid_q;
        assign o_data_out[j*WIDTH +: WIDTH] = data_q;
        assign o_dest_out[j*A +: A]    = dest_q;
    end

    // Fire counter saturates; together with the saturating rx counters this
    // makes done sticky until reset without a separate flag register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fires <= '0;
        end else if (fire && (fires < FW'(DONE_COUNT))) begin
            fires <= fires + 1'b1;
        end
    end

    assign done = (fires >= FW'(DONE_COUNT)) && (&rx_done);

endmodule

// File: tb/tb_via_n_m.sv
// ---------------------------------------------------------------------------
// tb_via_n_m
//
// Self-checking bench for via_n_m with two inputs and two outputs. A
// cycle-level reference model of tokens, output occupancy and counters
// drives a per-output scoreboard: expected flits are pushed when the model
// fires and popped/compared when the output handshakes.
// ---------------------------------------------------------------------------
module tb_via_n_m;

    localparam int NI    = 2;
    localparam int NO    = 2;
    localparam int W     = 32;
    localparam int A     = 4;
    localparam int DEPTH = 4;
    localparam int INIT  = 1;
    localparam int DC    = 10;

    logic              clk;
    logic              rst;
    logic              done;
    logic [NI*W-1:0]   i_data_in;
    logic [NI-1:0]     i_valid_in;
    logic [NI-1:0]     i_ready_out;
    logic [NO*W-1:0]   o_data_out;
    logic [NO*A-1:0]   o_dest_out;
    logic [NO-1:0]     o_valid_out;
    logic [NO-1:0]     o_ready_in;
    logic [NI-1:0]     seq_err;

    via_n_m #(
        .NUM_IN      (NI),
        .NUM_OUT     (NO),
        .WIDTH       (W),
        .N           (16),
        .NODE        (15),
        .DEPTH       (DEPTH),
        .INIT_TOKENS (INIT),
        .MAX_DEST    (4),
        .O_ID        (16'hB1A0),
        .I_ID        (16'h2120),
        .O_NUM_DEST  (16'h0203),
        .O_DEST      (32'h0095_0B73),
        .DONE_COUNT  (DC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .done        (done),
        .i_data_in   (i_data_in),
        .i_valid_in  (i_valid_in),
        .i_ready_out (i_ready_out),
        .o_data_out  (o_data_out),
        .o_dest_out  (o_dest_out),
        .o_valid_out (o_valid_out),
        .o_ready_in  (o_ready_in),
        .seq_err     (seq_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Destination lists: output 0 rotates 3,7,11; output 1 rotates 5,9
    int            dest_tab [NO][3];
    int            ndest    [NO];
    logic [7:0]    id_tab   [NO];

    // Reference model state
    int            tok_m   [NI];
    int            rx_m    [NI];
    int            exp_m   [NI];
    int            drv_seq [NI];
    bit            err_m   [NI];
    bit            vld_m   [NO];
    int            sent_m  [NO];
    int            fires_m;
    logic [31:0]   q0 [$];
    logic [31:0]   q1 [$];

    int            checks;
    int            failures;
    logic [31:0]   held0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, expv, $time);
        end
    endtask

    function automatic logic [31:0] expFlit(input int j, input int k);
        logic [3:0] d;
        d = 4'(dest_tab[j][k % ndest[j]]);
        return {4'hF, d, id_tab[j], 16'(k)};
    endfunction

    task automatic resetModel();
        for (int i = 0; i < NI; i++) begin
            tok_m[i]   = INIT;
            rx_m[i]    = 0;
            exp_m[i]   = 0;
            drv_seq[i] = 0;
            err_m[i]   = 1'b0;
        end
        for (int j = 0; j < NO; j++) begin
            vld_m[j]  = 1'b0;
            sent_m[j] = 0;
        end
        fires_m = 0;
        q0.delete();
        q1.delete();
    endtask

    task automatic checkState();
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("ready%0d", i), 32'(i_ready_out[i]), 32'(tok_m[i] < DEPTH));
        end
        checkOutput("valid", 32'(o_valid_out), {30'd0, vld_m[1], vld_m[0]});
        checkOutput("done", 32'(done),
                    32'(fires_m >= DC && rx_m[0] >= DC && rx_m[1] >= DC));
        checkOutput("seq_err", 32'(seq_err), {30'd0, err_m[1], err_m[0]});
    endtask

    task automatic popCompare(input int j);
        logic [31:0] e;
        int          sz;
        sz = (j == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            checkOutput($sformatf("out%0d_sb_nonempty", j), 32'(sz), 32'd1);
        end else begin
            e = (j == 0) ? q0.pop_front() : q1.pop_front();
            checkOutput($sformatf("out%0d_data", j), o_data_out[j*W +: W], e);
            checkOutput($sformatf("out%0d_dest", j), 32'(o_dest_out[j*A +: A]), 32'(e[27:24]));
        end
    endtask

    // Checks the current outputs, drives one cycle of inputs, advances the
    // model across the coming rising edge and waits for the next falling edge.
    task automatic applyStimulus(input logic [1:0] vin, input logic [1:0] ordy);
        bit acc [NI];
        bit fire;
        checkState();
        i_valid_in = vin;
        o_ready_in = ordy;
        for (int i = 0; i < NI; i++) begin
            i_data_in[i*W +: W] = {4'(i), 4'hF, 8'(8'h20 + i), 16'(drv_seq[i])};
            acc[i] = vin[i] && (tok_m[i] < DEPTH);
        end
        fire = (tok_m[0] > 0) && (tok_m[1] > 0) &&
               (!vld_m[0] || ordy[0]) && (!vld_m[1] || ordy[1]);
        for (int j = 0; j < NO; j++) begin
            if (vld_m[j] && ordy[j]) begin
                popCompare(j);
                vld_m[j] = 1'b0;
            end
        end
        if (fire) begin
            q0.push_back(expFlit(0, sent_m[0]));
            q1.push_back(expFlit(1, sent_m[1]));
            for (int j = 0; j < NO; j++) begin
                vld_m[j] = 1'b1;
                sent_m[j]++;
            end
            if (fires_m < DC) fires_m++;
        end
        for (int i = 0; i < NI; i++) begin
            tok_m[i] = tok_m[i] + int'(acc[i]) - int'(fire);
            if (acc[i]) begin
                if (rx_m[i] < DC) rx_m[i]++;
`ifdef VIA_SEQ_CHECK_EN
                if ((drv_seq[i] & 16'hFFFF) != exp_m[i]) err_m[i] = 1'b1;
`endif
                exp_m[i]   = (drv_seq[i] + 1) & 16'hFFFF;
                drv_seq[i] = (drv_seq[i] + 1) & 16'hFFFF;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        dest_tab = '{'{3, 7, 11}, '{5, 9, 0}};
        ndest    = '{3, 2};
        id_tab   = '{8'hA0, 8'hB1};

        rst        = 1'b0;
        i_valid_in = '0;
        i_data_in  = '0;
        o_ready_in = '0;
        resetModel();

        // Reset values
        repeat (2) @(negedge clk);
        checkState();
        checkOutput("dest_rst", 32'(o_dest_out), 32'd0);
        checkOutput("data_rst", o_data_out[31:0], 32'd0);
        rst = 1'b1;

        // Preloaded tokens fire on the first edge after reset
        repeat (3) applyStimulus(2'b00, 2'b11);

        // Output 0 stalls: data held, output 1 drains, no further fire
        applyStimulus(2'b11, 2'b11);
        applyStimulus(2'b00, 2'b10);
        held0 = o_data_out[31:0];
        repeat (5) begin
            applyStimulus(2'b11, 2'b10);
            checkOutput("out0_hold_data", o_data_out[31:0], held0);
        end
        repeat (3) applyStimulus(2'b00, 2'b11);

        // Only input 0 delivers: it fills to DEPTH and ready drops
        repeat (8) applyStimulus(2'b01, 2'b11);
        checkOutput("in0_full_ready", 32'(i_ready_out[0]), 32'd0);
        repeat (6) applyStimulus(2'b10, 2'b11);

        // Sequence gap on input 1
        repeat (3) applyStimulus(2'b11, 2'b11);
        drv_seq[1] = (drv_seq[1] + 1) & 16'hFFFF;
        repeat (4) applyStimulus(2'b11, 2'b11);

        // Random traffic and backpressure
        for (int c = 0; c < 300; c++) begin
            applyStimulus(2'($urandom), 2'($urandom));
        end
        repeat (6) applyStimulus(2'b11, 2'b11);
        checkOutput("done_reached", 32'(done), 32'd1);

        // Asynchronous reset while outputs are valid
        #2;
        rst = 1'b0;
        #1;
        checkOutput("valid_async_rst", 32'(o_valid_out), 32'd0);
        checkOutput("done_async_rst", 32'(done), 32'd0);
        checkOutput("dest_async_rst", 32'(o_dest_out), 32'd0);
        resetModel();
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(2'($urandom), 2'($urandom));
        end
        checkState();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
